// File: rtl/pinaipple_l1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pinaipple_l1_pkg
// Description : Shared types and defaults for L1 interconnect device adapters.
// Revision    : 1.0 - initial release
// ============================================================================
package pinaipple_l1_pkg;

    localparam int unsigned c_data_width     = 32;
    localparam int unsigned c_addr_width     = 20;
    localparam int unsigned c_nbr_hosts_log2 = 1;
    localparam int unsigned c_resp_depth     = 2;
    localparam int unsigned c_dev_addr_width = 32;

    function automatic int unsigned resp_width(input int unsigned ini_w,
                                               input int unsigned data_w);
        return ini_w + data_w;
    endfunction

    localparam int unsigned c_resp_width = resp_width(c_nbr_hosts_log2, c_data_width);

    typedef struct packed {
        logic [c_nbr_hosts_log2-1:0] ini_addr;
        logic [c_data_width-1:0]     rdata;
    } l1_resp_t;

    typedef enum logic [2:0] {
        BUS_DEV_RAM      = 3'd0,
        BUS_DEV_GPIO     = 3'd1,
        BUS_DEV_UART     = 3'd2,
        BUS_DEV_TIMER    = 3'd3,
        BUS_DEV_SIM_CTRL = 3'd4
    } bus_device_e;

endpackage
`default_nettype wire

// File: rtl/l1_device_adapter_if.sv
`default_nettype none
// ============================================================================
// Module      : l1_net_if / l1_dev_if
// Description : Interconnect-side and peripheral-side buses of the adapter.
// Revision    : 1.0 - initial release
// ============================================================================
interface l1_net_if import pinaipple_l1_pkg::*; #(
    parameter int unsigned DATA_WIDTH     = c_data_width,
    parameter int unsigned ADDR_WIDTH     = c_addr_width,
    parameter int unsigned NBR_HOSTS_LOG2 = c_nbr_hosts_log2
) ();
    logic                      req_valid;
    logic                      req_ready;
    logic [NBR_HOSTS_LOG2-1:0] req_ini_addr;
    logic [ADDR_WIDTH-1:0]     req_tgt_addr;
    logic                      req_wen;
    logic [DATA_WIDTH/8-1:0]   req_be;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [NBR_HOSTS_LOG2-1:0] resp_ini_addr;
    logic [DATA_WIDTH-1:0]     resp_rdata;

    modport master (
        output req_valid, req_ini_addr, req_tgt_addr, req_wen, req_be, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_ini_addr, resp_rdata
    );

    modport slave (
        input  req_valid, req_ini_addr, req_tgt_addr, req_wen, req_be, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_ini_addr, resp_rdata
    );
endinterface

interface l1_dev_if import pinaipple_l1_pkg::*; #(
    parameter int unsigned DATA_WIDTH = c_data_width
) ();
    logic                        dev_req;
    logic                        dev_we;
    logic [DATA_WIDTH/8-1:0]     dev_be;
    logic [c_dev_addr_width-1:0] dev_addr;
    logic [DATA_WIDTH-1:0]       dev_wdata;
    logic                        dev_rvalid;
    logic [DATA_WIDTH-1:0]       dev_rdata;

    modport master (
        output dev_req, dev_we, dev_be, dev_addr, dev_wdata,
        input  dev_rvalid, dev_rdata
    );

    modport slave (
        input  dev_req, dev_we, dev_be, dev_addr, dev_wdata,
        output dev_rvalid, dev_rdata
    );
endinterface
`default_nettype wire

// File: rtl/l1_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : l1_resp_fifo
// Description : Synchronous response FIFO, power-of-2 depth, show-ahead head.
// Revision    : 1.0 - initial release
// ============================================================================
module l1_resp_fifo import pinaipple_l1_pkg::*; #(
    parameter type         T     = l1_resp_t,
    parameter int unsigned DEPTH = c_resp_depth
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_ni,
    input  wire logic                 i_push,
    input  wire logic                 i_pop,
    input  wire T                     i_data,
    output T                          o_data,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int unsigned          c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]     c_depth = DEPTH[c_ptr_w:0];

    T                   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_depth);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/l1_device_adapter.sv
`default_nettype none
// ============================================================================
// Module      : l1_device_adapter
// Description : Bridges an L1 interconnect device port to a fixed-latency peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
module l1_device_adapter import pinaipple_l1_pkg::*; #(
    parameter int unsigned DATA_WIDTH     = c_data_width,
    parameter int unsigned ADDR_WIDTH     = c_addr_width,
    parameter int unsigned NBR_HOSTS_LOG2 = c_nbr_hosts_log2,
    parameter int unsigned RESP_DEPTH     = c_resp_depth
) (
    input  wire logic clk_i,
    input  wire logic rst_ni,
    l1_net_if.slave   net,
    l1_dev_if.master  dev,
    output logic      proto_err_o
);

    localparam int unsigned        c_cnt_w = $clog2(RESP_DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_depth = RESP_DEPTH[c_cnt_w-1:0];

    typedef struct packed {
        logic [NBR_HOSTS_LOG2-1:0] ini_addr;
        logic [DATA_WIDTH-1:0]     rdata;
    } resp_t;

    logic                        r_inflight;
    logic [NBR_HOSTS_LOG2-1:0]   r_id;
    logic                        r_proto_err;
    logic                        w_accept;
    logic                        w_rsp;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_overflow;
    logic                        w_spurious;
    logic                        w_missing;
    logic [c_cnt_w-1:0]          w_count;
    logic [c_dev_addr_width-1:0] w_addr_ext;
    resp_t                       w_new;
    resp_t                       w_head;

    // Credit reserves one FIFO slot for the response still owed by the peripheral.
    assign net.req_ready = (w_count + c_cnt_w'(r_inflight)) < c_depth;
    assign w_accept      = net.req_valid & net.req_ready;

    always_comb begin
        w_addr_ext                 = '0;
        w_addr_ext[ADDR_WIDTH-1:0] = net.req_tgt_addr;
    end

    assign dev.dev_req   = w_accept;
    assign dev.dev_we    = net.req_wen;
    assign dev.dev_be    = net.req_be;
    assign dev.dev_addr  = w_addr_ext;
    assign dev.dev_wdata = net.req_wdata;

    assign w_rsp      = dev.dev_rvalid & r_inflight;
    assign w_new      = '{ini_addr: r_id, rdata: dev.dev_rdata};
    // A bypassed response only needs buffering if the network refuses it this cycle.
    assign w_push     = w_rsp & ~(w_empty & net.resp_ready);
    assign w_pop      = ~w_empty & net.resp_ready;
    assign w_overflow = w_push & w_full;
    assign w_spurious = dev.dev_rvalid & ~r_inflight;
    assign w_missing  = r_inflight & ~dev.dev_rvalid;

    always_comb begin
        net.resp_valid    = 1'b0;
        net.resp_ini_addr = '0;
        net.resp_rdata    = '0;
        if (!w_empty) begin
            net.resp_valid    = 1'b1;
            net.resp_ini_addr = w_head.ini_addr;
            net.resp_rdata    = w_head.rdata;
        end else if (w_rsp) begin
            net.resp_valid    = 1'b1;
            net.resp_ini_addr = w_new.ini_addr;
            net.resp_rdata    = w_new.rdata;
        end
    end

    l1_resp_fifo #(
        .T     (resp_t),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_new),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inflight  <= 1'b0;
            r_id        <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_inflight <= w_accept;
            if (w_accept) begin
                r_id <= net.req_ini_addr;
            end
            if (w_spurious | w_missing | w_overflow) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign proto_err_o = r_proto_err;

endmodule
`default_nettype wire
